// File: rtl/assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : assoc_cache
// Brief    : K-way set-associative word-line cache with true-LRU replacement,
//            victim reporting and snoop invalidation; registered responses.
// Revision : 1.0  initial release
// ============================================================================
module assoc_cache #(
    parameter int SET_COUNT  = 4,
    parameter int WAYS       = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [LINE_WIDTH-1:0] in_val,
    input  logic                  read,
    input  logic                  write,
    input  logic                  bus_valid,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  done,
    output logic                  hit,
    output logic [LINE_WIDTH-1:0] out_val,
    output logic                  evict_valid,
    output logic [ADDR_WIDTH-1:0] evict_addr,
    output logic [LINE_WIDTH-1:0] evict_val
);

    localparam int c_IDX_W = $clog2(SET_COUNT);
    localparam int c_TAG_W = ADDR_WIDTH - c_IDX_W;
    localparam int c_AGE_W = $clog2(WAYS);

    logic                  r_valid [SET_COUNT][WAYS];
    logic [c_TAG_W-1:0]    r_tag   [SET_COUNT][WAYS];
    logic [LINE_WIDTH-1:0] r_data  [SET_COUNT][WAYS];
    logic [c_AGE_W-1:0]    r_age   [SET_COUNT][WAYS];

    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic [c_IDX_W-1:0] w_sidx;
    logic [c_TAG_W-1:0] w_stag;
    logic               w_hit;
    logic [c_AGE_W-1:0] w_hit_way;
    logic               w_has_inv;
    logic [c_AGE_W-1:0] w_inv_way;
    logic [c_AGE_W-1:0] w_lru_way;
    logic               w_snp_hit;
    logic [c_AGE_W-1:0] w_snp_way;
    logic [c_AGE_W-1:0] w_victim;
    logic [c_AGE_W-1:0] w_acc_way;
    logic [c_AGE_W-1:0] w_old_age;
    logic               w_collide;
    logic               w_do_write;
    logic               w_do_read;
    logic               w_fill;
    logic               w_touch;

    assign w_idx  = in_addr[c_IDX_W-1:0];
    assign w_tag  = in_addr[ADDR_WIDTH-1:c_IDX_W];
    assign w_sidx = bus_addr[c_IDX_W-1:0];
    assign w_stag = bus_addr[ADDR_WIDTH-1:c_IDX_W];

    // Downward scan so the lowest-index invalid way is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        w_lru_way = '0;
        w_snp_hit = 1'b0;
        w_snp_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_AGE_W'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = c_AGE_W'(w);
            end
            if (r_age[w_idx][w] == c_AGE_W'(WAYS - 1)) begin
                w_lru_way = c_AGE_W'(w);
            end
            if (r_valid[w_sidx][w] && (r_tag[w_sidx][w] == w_stag)) begin
                w_snp_hit = 1'b1;
                w_snp_way = c_AGE_W'(w);
            end
        end
    end

    assign w_victim   = w_has_inv ? w_inv_way : w_lru_way;
    assign w_acc_way  = w_hit ? w_hit_way : w_victim;
    assign w_old_age  = r_age[w_idx][w_acc_way];
    assign w_collide  = bus_valid && write && (bus_addr == in_addr);
    assign w_do_write = write && !w_collide;
    assign w_do_read  = read && !write;
    assign w_fill     = w_do_write && !w_hit;
    assign w_touch    = (w_do_read && w_hit) || w_do_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SET_COUNT; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_age[s][w]   <= c_AGE_W'(w);
                end
            end
            done        <= 1'b0;
            hit         <= 1'b0;
            out_val     <= '0;
            evict_valid <= 1'b0;
            evict_addr  <= '0;
            evict_val   <= '0;
        end else begin
            // A fill into the snooped slot replaces the line, so it is applied last.
            if (bus_valid && w_snp_hit) begin
                r_valid[w_sidx][w_snp_way] <= 1'b0;
            end
            if (w_fill) begin
                r_valid[w_idx][w_victim] <= 1'b1;
            end
            if (w_touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (c_AGE_W'(w) == w_acc_way) begin
                        r_age[w_idx][w] <= '0;
                    end else if (r_age[w_idx][w] < w_old_age) begin
                        r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                    end
                end
            end
            done        <= read || write;
            hit         <= w_hit && (w_do_read || w_do_write);
            out_val     <= (w_do_read && w_hit) ? r_data[w_idx][w_hit_way] : '0;
            evict_valid <= w_fill && !w_has_inv;
            evict_addr  <= (w_fill && !w_has_inv) ? {r_tag[w_idx][w_victim], w_idx} : '0;
            evict_val   <= (w_fill && !w_has_inv) ? r_data[w_idx][w_victim] : '0;
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies them.
    always_ff @(posedge clock) begin
        if (!reset && w_do_write) begin
            r_tag[w_idx][w_acc_way]  <= w_tag;
            r_data[w_idx][w_acc_way] <= in_val;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_assoc_cache
// Brief    : Directed and randomized check of assoc_cache against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_assoc_cache;

    localparam int c_SETS = 4;
    localparam int c_WAYS = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_addr = '0;
    logic [31:0] in_val = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        bus_valid = 1'b0;
    logic [7:0]  bus_addr = '0;
    logic        done;
    logic        hit;
    logic [31:0] out_val;
    logic        evict_valid;
    logic [7:0]  evict_addr;
    logic [31:0] evict_val;

    assoc_cache #(
        .SET_COUNT(4), .WAYS(2), .ADDR_WIDTH(8), .LINE_WIDTH(32)
    ) dut (
        .clock(clock), .reset(reset), .in_addr(in_addr), .in_val(in_val),
        .read(read), .write(write), .bus_valid(bus_valid), .bus_addr(bus_addr),
        .done(done), .hit(hit), .out_val(out_val), .evict_valid(evict_valid),
        .evict_addr(evict_addr), .evict_val(evict_val)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: a plain table of lines plus an age per way.
    bit          mv [c_SETS][c_WAYS];
    logic [5:0]  mt [c_SETS][c_WAYS];
    logic [31:0] md [c_SETS][c_WAYS];
    int          ma [c_SETS][c_WAYS];

    logic        e_done = 1'b0, e_hit = 1'b0, e_ev = 1'b0;
    logic [31:0] e_out = '0, e_eval = '0;
    logic [7:0]  e_eaddr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic touch(input int s, input int w);
        int a;
        a = ma[s][w];
        for (int i = 0; i < c_WAYS; i++) if (ma[s][i] < a) ma[s][i]++;
        ma[s][w] = 0;
    endtask

    task automatic model_step(input bit rst, input bit rd, input bit wr, input logic [7:0] a,
                              input logic [31:0] v, input bit bv, input logic [7:0] ba);
        int s, hw, vic, bs;
        logic [5:0] t, bt;
        e_done = 0; e_hit = 0; e_out = 0; e_ev = 0; e_eaddr = 0; e_eval = 0;
        if (rst) begin
            for (int i = 0; i < c_SETS; i++)
                for (int w = 0; w < c_WAYS; w++) begin
                    mv[i][w] = 0;
                    ma[i][w] = w;
                end
            return;
        end
        s = int'(a[1:0]);
        t = a[7:2];
        hw = -1;
        for (int w = 0; w < c_WAYS; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
        e_done = rd | wr;
        if (wr) begin
            if (!(bv && ba == a)) begin
                if (hw >= 0) begin
                    e_hit = 1;
                    md[s][hw] = v;
                    touch(s, hw);
                end else begin
                    vic = -1;
                    for (int w = 0; w < c_WAYS; w++) if (!mv[s][w] && vic < 0) vic = w;
                    if (vic < 0)
                        for (int w = 0; w < c_WAYS; w++) if (ma[s][w] == c_WAYS - 1) vic = w;
                    if (mv[s][vic]) begin
                        e_ev = 1;
                        e_eaddr = {mt[s][vic], a[1:0]};
                        e_eval = md[s][vic];
                    end
                    mv[s][vic] = 1;
                    mt[s][vic] = t;
                    md[s][vic] = v;
                    touch(s, vic);
                end
            end
        end else if (rd && hw >= 0) begin
            e_hit = 1;
            e_out = md[s][hw];
            touch(s, hw);
        end
        // The snooped address is gone afterwards, whichever way still holds it.
        if (bv) begin
            bs = int'(ba[1:0]);
            bt = ba[7:2];
            for (int w = 0; w < c_WAYS; w++) if (mv[bs][w] && mt[bs][w] == bt) mv[bs][w] = 0;
        end
    endtask

    task automatic op(input bit rst, input bit rd, input bit wr, input logic [7:0] a,
                      input logic [31:0] v, input bit bv, input logic [7:0] ba);
        @(negedge clock);
        reset = rst; read = rd; write = wr; in_addr = a; in_val = v;
        bus_valid = bv; bus_addr = ba;
        model_step(rst, rd, wr, a, v, bv, ba);
    endtask

    task automatic lit(input string name, input bit d, input bit h, input logic [31:0] v);
        @(posedge clock);
        #2;
        chk({name, ".done"}, 32'(done), 32'(d));
        chk({name, ".hit"}, 32'(hit), 32'(h));
        chk({name, ".val"}, out_val, v);
    endtask

    task automatic lit_ev(input string name, input bit ev, input logic [7:0] ea, input logic [31:0] ed);
        @(posedge clock);
        #2;
        chk({name, ".ev"}, 32'(evict_valid), 32'(ev));
        chk({name, ".eaddr"}, 32'(evict_addr), 32'(ea));
        chk({name, ".eval"}, evict_val, ed);
    endtask

    always @(posedge clock) begin
        #1;
        chk("done", 32'(done), 32'(e_done));
        chk("hit", 32'(hit), 32'(e_hit));
        chk("out_val", out_val, e_out);
        chk("evict_valid", 32'(evict_valid), 32'(e_ev));
        chk("evict_addr", 32'(evict_addr), 32'(e_eaddr));
        chk("evict_val", evict_val, e_eval);
    end

    initial begin
        bit rr, rd, wr, bv;
        logic [7:0] a, ba;
        model_step(1, 0, 0, 0, 0, 0, 0);
        op(1, 0, 0, 8'h00, 0, 0, 8'h00);
        op(1, 0, 0, 8'h00, 0, 0, 8'h00);
        lit("reset", 0, 0, 0);

        op(0, 1, 0, 8'h15, 0, 0, 0);                 lit("cold_read", 1, 0, 0);
        op(0, 0, 1, 8'h15, 32'hDEADBEEF, 0, 0);
        op(0, 1, 0, 8'h15, 0, 0, 0);                 lit("raw_hit", 1, 1, 32'hDEADBEEF);

        op(0, 0, 1, 8'h04, 32'hA, 0, 0);
        op(0, 0, 1, 8'h08, 32'hB, 0, 0);
        op(0, 1, 0, 8'h04, 0, 0, 0);
        op(0, 0, 1, 8'h0C, 32'hC, 0, 0);             lit_ev("lru_evict", 1, 8'h08, 32'hB);
        op(0, 1, 0, 8'h04, 0, 0, 0);                 lit("keep_04", 1, 1, 32'hA);
        op(0, 1, 0, 8'h0C, 0, 0, 0);                 lit("keep_0c", 1, 1, 32'hC);
        op(0, 1, 0, 8'h08, 0, 0, 0);                 lit("gone_08", 1, 0, 0);

        op(0, 0, 1, 8'h21, 32'd1, 0, 0);
        op(0, 0, 1, 8'h21, 32'd2, 0, 0);             lit_ev("whit_noev", 0, 0, 0);
        op(0, 1, 0, 8'h21, 0, 0, 0);                 lit("whit_data", 1, 1, 32'd2);

        op(0, 0, 1, 8'h31, 32'd7, 0, 0);
        op(0, 1, 0, 8'h31, 0, 1, 8'h31);             lit("snoop_rd", 1, 1, 32'd7);
        op(0, 1, 0, 8'h31, 0, 0, 0);                 lit("snoop_gone", 1, 0, 0);
        op(0, 0, 1, 8'h45, 32'd9, 0, 0);             lit_ev("snoop_refill", 0, 0, 0);

        op(0, 0, 1, 8'h42, 32'd5, 1, 8'h42);         lit("collide", 1, 0, 0);
        op(0, 1, 0, 8'h42, 0, 0, 0);                 lit("collide_rd", 1, 0, 0);

        op(0, 0, 1, 8'h10, 32'd3, 0, 0);
        op(1, 1, 0, 8'h10, 0, 0, 0);                 lit("rst_drop", 0, 0, 0);
        op(0, 1, 0, 8'h10, 0, 0, 0);                 lit("post_rst_10", 1, 0, 0);
        op(0, 1, 0, 8'h04, 0, 0, 0);                 lit("post_rst_04", 1, 0, 0);
        op(0, 1, 0, 8'h21, 0, 0, 0);                 lit("post_rst_21", 1, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 149) == 0);
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            a  = 8'($urandom_range(0, 31));
            bv = ($urandom_range(0, 3) == 0);
            ba = ($urandom_range(0, 2) == 0) ? a : 8'($urandom_range(0, 31));
            op(rr, rd, wr, a, $urandom, bv, ba);
        end
        op(0, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
